// File: rtl/decoder8_pipe_pkg.sv
// Shared constants, types and helpers for the 8-way one-hot decoder link.
// The matching encoder imports DEC8_CODE_NONE from here.
package decoder8_pipe_pkg;

    localparam int          DEC8_OUT_W     = 8;
    localparam int          DEC8_CODE_W    = 4;
    localparam logic [3:0]  DEC8_CODE_NONE = 4'b1111;

    localparam logic [1:0]  DEC8_ST_EMPTY  = 2'd0;
    localparam logic [1:0]  DEC8_ST_ONE    = 2'd1;
    localparam logic [1:0]  DEC8_ST_TWO    = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = DEC8_ST_EMPTY,
        ST_ONE   = DEC8_ST_ONE,
        ST_TWO   = DEC8_ST_TWO
    } dec8_state_e;

    typedef struct packed {
        logic [DEC8_OUT_W-1:0] vec;
        logic                  none;
        logic                  err;
    } dec8_entry_t;

    function automatic logic [DEC8_OUT_W-1:0] dec8_onehot(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/decoder8_pipe_if.sv
// Valid/ready bundle for the decoder: code stream in, decoded entry stream out.
interface decoder8_pipe_if;
    import decoder8_pipe_pkg::*;

    logic [DEC8_CODE_W-1:0] in_code;
    logic                   in_valid;
    logic                   in_ready;
    logic [DEC8_OUT_W-1:0]  out;
    logic                   out_none;
    logic                   out_err;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  in_code, in_valid, out_ready,
        output in_ready, out, out_none, out_err, out_valid
    );

    modport master (
        output in_code, in_valid, out_ready,
        input  in_ready, out, out_none, out_err, out_valid
    );

endinterface

// File: rtl/decode8_lut.sv
// Combinational code-to-entry map: 0..7 one-hot, 4'b1111 none, 8..14 illegal.
module decode8_lut
    import decoder8_pipe_pkg::*;
(
    input  logic [DEC8_CODE_W-1:0] code,
    output dec8_entry_t            entry
);

    // Decode one code into {vec, none, err}; none and err are mutually exclusive.
    always_comb begin
        entry = '0;
        case (code[3])
            1'b0: entry.vec = dec8_onehot(code[2:0]);
            1'b1: begin
                if (code == DEC8_CODE_NONE) begin
                    entry.none = 1'b1;
                end else begin
                    entry.err = 1'b1;
                end
            end
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/decoder8_pipe.sv
// Decoder receiving end: input-side decode, 2-entry skid buffer, occupancy FSM.
// Define DEC8_ERR_CNT_EN to add the saturating illegal-code counter and ERR_CNT port.
module decoder8_pipe
    import decoder8_pipe_pkg::*;
`ifdef DEC8_ERR_CNT_EN
#(
    parameter int ERR_CNT_W = 8
)
`endif
(
    input  logic                 clk,
    input  logic                 rst,
    decoder8_pipe_if.slave       bus
`ifdef DEC8_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    dec8_state_e state_r;
    dec8_entry_t head_r;
    dec8_entry_t skid_r;
    dec8_entry_t dec_s;
    logic        push_s;
    logic        pop_s;

    decode8_lut u_lut (
        .code  (bus.in_code),
        .entry (dec_s)
    );

    // Handshakes depend only on state and reset, never on out_ready.
    assign bus.in_ready  = !rst && (state_r != ST_TWO);
    assign bus.out_valid = (state_r != ST_EMPTY);
    assign push_s        = bus.in_valid && bus.in_ready;
    assign pop_s         = bus.out_valid && bus.out_ready;

    assign bus.out      = head_r.vec;
    assign bus.out_none = head_r.none;
    assign bus.out_err  = head_r.err;

    // Occupancy FSM; head_r drives the outputs, skid_r catches the entry behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            head_r  <= '0;
            skid_r  <= '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        head_r  <= dec_s;
                        state_r <= ST_ONE;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        head_r  <= dec_s;
                        state_r <= ST_ONE;
                    end else if (push_s) begin
                        skid_r  <= dec_s;
                        state_r <= ST_TWO;
                    end else if (pop_s) begin
                        head_r  <= '0;
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        head_r  <= skid_r;
                        skid_r  <= '0;
                        state_r <= ST_ONE;
                    end else begin
                        state_r <= ST_TWO;
                    end
                end
                default: begin
                    head_r  <= '0;
                    skid_r  <= '0;
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef DEC8_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Count illegal codes at acceptance, holding at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else if (push_s && dec_s.err && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_decoder8_pipe.sv
// Self-checking bench for decoder8_pipe: queue-based reference model plus directed literal checks.
module tb_decoder8_pipe;
    import decoder8_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decoder8_pipe_if bus();

`ifdef DEC8_ERR_CNT_EN
    localparam int EW = 8;
    logic [EW-1:0] err_cnt;
    decoder8_pipe #(.ERR_CNT_W(EW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_cnt (err_cnt)
    );
`else
    decoder8_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    localparam int EMAX = 255;

    int         tests = 0;
    int         fails = 0;
    logic [3:0] q[$];
    int         exp_cnt = 0;

    function automatic logic [7:0] exp_vec(input logic [3:0] c);
        if (c < 4'd8) return 8'd1 << c;
        return 8'd0;
    endfunction

    function automatic bit is_illegal(input logic [3:0] c);
        return (c >= 4'd8) && (c != 4'd15);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model state.
    task automatic compare();
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(!rst && (q.size() < 2)));
        if (q.size() > 0) begin
            chk("out", 32'(bus.out), 32'(exp_vec(q[0])));
            chk("out_none", 32'(bus.out_none), 32'(q[0] == 4'd15));
            chk("out_err", 32'(bus.out_err), 32'(is_illegal(q[0])));
        end
`ifdef DEC8_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
    endtask

    // One clock: decide transfers from the model, advance it, then compare.
    task automatic cycle();
        bit         push;
        bit         pop;
        logic [3:0] c;
        push = !rst && bus.in_valid && (q.size() < 2);
        pop  = bus.out_ready && (q.size() > 0);
        c    = bus.in_code;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(c);
                if (is_illegal(c) && exp_cnt < EMAX) exp_cnt++;
            end
        end
        compare();
    endtask

    initial begin
        int r;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_code   = 4'd0;
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_none", 32'(bus.out_none), 32'h0);
        chk("rst_err", 32'(bus.out_err), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        rst = 1'b0;
        cycle();
        chk("rel_in_ready", 32'(bus.in_ready), 32'h1);

        // Single code, one-cycle latency
        bus.in_code = 4'd3; bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        chk("t1_out", 32'(bus.out), 32'h08);
        chk("t1_valid", 32'(bus.out_valid), 32'h1);
        cycle();
        chk("t1_valid_drop", 32'(bus.out_valid), 32'h0);

        // Back-to-back sweep 0..7
        for (int i = 0; i < 8; i++) begin
            bus.in_code = 4'(i); bus.in_valid = 1'b1;
            cycle();
            chk("t2_out", 32'(bus.out), 32'h1 << i);
            chk("t2_in_ready", 32'(bus.in_ready), 32'h1);
        end
        bus.in_valid = 1'b0;
        cycle();

        // None and illegal codes
        bus.in_code = 4'b1111; bus.in_valid = 1'b1;
        cycle();
        chk("t3_none_out", 32'(bus.out), 32'h0);
        chk("t3_none_flag", 32'(bus.out_none), 32'h1);
        chk("t3_none_err", 32'(bus.out_err), 32'h0);
        bus.in_code = 4'b1010;
        cycle();
        bus.in_valid = 1'b0;
        chk("t3_ill_out", 32'(bus.out), 32'h0);
        chk("t3_ill_none", 32'(bus.out_none), 32'h0);
        chk("t3_ill_flag", 32'(bus.out_err), 32'h1);
`ifdef DEC8_ERR_CNT_EN
        chk("t3_err_cnt", 32'(err_cnt), 32'h1);
`endif
        cycle();

        // Fill to TWO with consumer stalled, then drain
        bus.out_ready = 1'b0;
        bus.in_code = 4'd5; bus.in_valid = 1'b1;
        cycle();
        bus.in_code = 4'd6;
        cycle();
        bus.in_valid = 1'b0;
        chk("t4_full_ready", 32'(bus.in_ready), 32'h0);
        chk("t4_hold", 32'(bus.out), 32'h20);
        cycle();
        chk("t4_hold2", 32'(bus.out), 32'h20);
        bus.out_ready = 1'b1;
        cycle();
        chk("t4_second", 32'(bus.out), 32'h40);
        chk("t4_ready_back", 32'(bus.in_ready), 32'h1);
        cycle();
        chk("t4_drained", 32'(bus.out_valid), 32'h0);

        // Reset while full discards both entries
        bus.out_ready = 1'b0;
        bus.in_code = 4'd2; bus.in_valid = 1'b1;
        cycle();
        cycle();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        chk("t5_valid", 32'(bus.out_valid), 32'h0);
        chk("t5_out", 32'(bus.out), 32'h0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_code = 4'd1; bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        chk("t5_fresh", 32'(bus.out), 32'h02);
        cycle();

`ifdef DEC8_ERR_CNT_EN
        // Drive the counter into saturation
        for (int i = 0; i < 270; i++) begin
            bus.in_code = 4'(8 + (i % 7)); bus.in_valid = 1'b1;
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        chk("t6_sat", 32'(err_cnt), 32'd255);
`endif

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       bus.in_code = 4'($urandom_range(0, 7));
            else if (r == 8) bus.in_code = 4'd15;
            else             bus.in_code = 4'($urandom_range(8, 14));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            rst           = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
